// File: rtl/snn_pkg.sv
// Shared types for the spiking-network datapath: driver FSM states, weight entry
// layout and the event counter width.
package snn_pkg;

  localparam int EVT_CNT_W    = 16;
  localparam int SYN_WEIGHT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EMIT = 2'd2
  } syn_state_e;

  typedef struct packed {
    logic                    excitatory;
    logic [SYN_WEIGHT_W-1:0] magnitude;
  } syn_entry_t;

endpackage

// File: rtl/syn_weight_ram.sv
// Synaptic weight store: one write port, one registered read port with enable.
// Read-first: a same-cycle write to the read address returns the old word.
module syn_weight_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int DW    = 9
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/synapse_event_driver.sv
// Spike fan-out engine: one accepted source ID becomes NUM_NEURONS weight beats.
// Optional build macro SYN_ZERO_SKIP_EN suppresses syn_valid for zero-magnitude slots.
module synapse_event_driver
  import snn_pkg::*;
#(
  parameter int NUM_SRC      = 64,
  parameter int NUM_NEURONS  = 16,
  parameter int WEIGHT_WIDTH = 8,
  parameter int SRC_ID_WIDTH = 6,
  parameter int NRN_ID_WIDTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 enable,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [SRC_ID_WIDTH-1:0]              in_src_id,
  input  logic                                 cfg_we,
  input  logic [SRC_ID_WIDTH+NRN_ID_WIDTH-1:0] cfg_addr,
  input  logic [WEIGHT_WIDTH:0]                cfg_wdata,
  output logic                                 cfg_drop,
  output logic                                 syn_valid,
  output logic [WEIGHT_WIDTH-1:0]              syn_weight,
  output logic                                 syn_excitatory,
  output logic [NRN_ID_WIDTH-1:0]              syn_target,
  output logic                                 busy,
  output logic [EVT_CNT_W-1:0]                 event_count
);

  localparam int AW = SRC_ID_WIDTH + NRN_ID_WIDTH;
  localparam int EW = WEIGHT_WIDTH + 1;
  localparam logic [NRN_ID_WIDTH-1:0] T_LAST = NRN_ID_WIDTH'(NUM_NEURONS - 1);

  syn_state_e              state_q;
  logic [SRC_ID_WIDTH-1:0] src_q;
  logic [NRN_ID_WIDTH-1:0] t_q;
  logic                    ready_q, drop_q;
  logic                    syn_valid_q, syn_exc_q;
  logic [WEIGHT_WIDTH-1:0] syn_weight_q;
  logic [NRN_ID_WIDTH-1:0] syn_target_q;
  logic [EVT_CNT_W-1:0]    cnt_q;

  logic          accept, ram_we, ram_re, beat_vld;
  logic [AW-1:0] ram_raddr;
  logic [EW-1:0] ram_rdata;

  assign accept = enable && ready_q && in_valid && (state_q == ST_IDLE);
  assign ram_we = enable && cfg_we && (state_q == ST_IDLE);

  // Reads run one slot ahead of the beat register so each EMIT cycle has its data.
  always_comb begin
    ram_re    = 1'b0;
    ram_raddr = {src_q, t_q + NRN_ID_WIDTH'(2)};
    case (state_q)
      ST_IDLE: begin
        ram_re    = accept;
        ram_raddr = {in_src_id, {NRN_ID_WIDTH{1'b0}}};
      end
      ST_READ: begin
        ram_re    = enable;
        ram_raddr = {src_q, NRN_ID_WIDTH'(1)};
      end
      ST_EMIT: ram_re = enable && ((int'(t_q) + 2) < NUM_NEURONS);
      default: ram_re = 1'b0;
    endcase
  end

`ifdef SYN_ZERO_SKIP_EN
  assign beat_vld = |ram_rdata[WEIGHT_WIDTH-1:0];
`else
  assign beat_vld = 1'b1;
`endif

  syn_weight_ram #(
    .DEPTH (NUM_SRC * NUM_NEURONS),
    .AW    (AW),
    .DW    (EW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (cfg_addr),
    .wdata_i (cfg_wdata),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      src_q        <= '0;
      t_q          <= '0;
      ready_q      <= 1'b0;
      drop_q       <= 1'b0;
      syn_valid_q  <= 1'b0;
      syn_exc_q    <= 1'b0;
      syn_weight_q <= '0;
      syn_target_q <= '0;
      cnt_q        <= '0;
    end else begin
      drop_q <= enable && cfg_we && (state_q != ST_IDLE);
      if (enable) begin
        case (state_q)
          ST_IDLE: begin
            syn_valid_q <= 1'b0;
            if (accept) begin
              src_q   <= in_src_id;
              cnt_q   <= cnt_q + EVT_CNT_W'(1);
              ready_q <= 1'b0;
              state_q <= ST_READ;
            end else begin
              ready_q <= 1'b1;
            end
          end
          ST_READ: begin
            syn_valid_q  <= beat_vld;
            syn_weight_q <= ram_rdata[WEIGHT_WIDTH-1:0];
            syn_exc_q    <= ram_rdata[WEIGHT_WIDTH];
            syn_target_q <= '0;
            t_q          <= '0;
            state_q      <= ST_EMIT;
          end
          ST_EMIT: begin
            if (t_q == T_LAST) begin
              syn_valid_q <= 1'b0;
              ready_q     <= 1'b1;
              state_q     <= ST_IDLE;
            end else begin
              // Beat register always shows slot t; load slot t+1 for the next cycle.
              syn_valid_q  <= beat_vld;
              syn_weight_q <= ram_rdata[WEIGHT_WIDTH-1:0];
              syn_exc_q    <= ram_rdata[WEIGHT_WIDTH];
              syn_target_q <= t_q + NRN_ID_WIDTH'(1);
              t_q          <= t_q + NRN_ID_WIDTH'(1);
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Gating by enable keeps each held beat visible on exactly one enabled edge.
  assign in_ready       = ready_q && enable;
  assign syn_valid      = syn_valid_q && enable;
  assign syn_weight     = syn_weight_q;
  assign syn_excitatory = syn_exc_q;
  assign syn_target     = syn_target_q;
  assign cfg_drop       = drop_q;
  assign busy           = (state_q != ST_IDLE);
  assign event_count    = cnt_q;

endmodule

// File: tb/tb_synapse_event_driver.sv
// Bench for synapse_event_driver: table-driven fan-out check, hand sequences for
// backpressure-free corner cases, and randomized events against a row model.
module tb_synapse_event_driver;
  import snn_pkg::*;

  localparam int NS = 64, NN = 16, WW = 8, SW = 6, NW = 4;

  logic clk = 1'b0;
  logic rst_n, enable, in_valid, in_ready, cfg_we, cfg_drop;
  logic syn_valid, syn_excitatory, busy;
  logic [SW-1:0]    in_src_id;
  logic [SW+NW-1:0] cfg_addr;
  logic [WW:0]      cfg_wdata;
  logic [WW-1:0]    syn_weight;
  logic [NW-1:0]    syn_target;
  logic [15:0]      event_count;

  always #5 clk = ~clk;

  synapse_event_driver #(
    .NUM_SRC(NS), .NUM_NEURONS(NN), .WEIGHT_WIDTH(WW), .SRC_ID_WIDTH(SW), .NRN_ID_WIDTH(NW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready), .in_src_id(in_src_id),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_drop(cfg_drop),
    .syn_valid(syn_valid), .syn_weight(syn_weight), .syn_excitatory(syn_excitatory),
    .syn_target(syn_target), .busy(busy), .event_count(event_count)
  );

  typedef struct {int cyc; int tgt; int w; int exc;} beat_t;
  typedef struct {syn_entry_t wdata; int exp_tgt; int exp_w; int exp_exc;} vec_t;

  beat_t      beats[$];
  vec_t       vt[NN];
  logic [WW:0] mdl [NS][NN];
  int cyc = 0;
  int tests = 0, fails = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (syn_valid === 1'b1)
      beats.push_back('{cyc, int'(syn_target), int'(syn_weight), int'(syn_excitatory)});

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic int pack(input int t, input int e, input int w);
    return t * 1024 + e * 512 + w;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(input int s, input int t, input logic [WW:0] d);
    cfg_we = 1'b1; cfg_addr = {s[SW-1:0], t[NW-1:0]}; cfg_wdata = d;
    nxt();
    cfg_we = 1'b0;
    mdl[s][t] = d;
  endtask

  task automatic send(input int s, output int acc);
    bit got;
    got = 0; acc = -1;
    in_valid = 1'b1; in_src_id = s[SW-1:0];
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin acc = cyc; got = 1; end
      nxt();
    end
    in_valid = 1'b0;
    chk("accepted", int'(got), 1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (busy === 1'b0) done = 1;
      nxt();
    end
    chk("idle_reached", int'(done), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; nxt(); nxt(); rst_n = 1'b1; nxt(); nxt();
  endtask

  // Expected beats come straight from the row model; zero slots vanish when skipping.
  task automatic expect_row(input string nm, input int s, input int acc, input bit chk_cyc);
    int n;
    bit keep;
    logic [WW:0] e;
    n = 0;
    for (int t = 0; t < NN; t++) begin
      e = mdl[s][t];
      keep = 1;
`ifdef SYN_ZERO_SKIP_EN
      keep = (e[WW-1:0] != 0);
`endif
      if (keep) begin
        if (n < beats.size()) begin
          chk($sformatf("%s_s%0d_t%0d", nm, s, t),
              pack(beats[n].tgt, beats[n].exc, beats[n].w), pack(t, int'(e[WW]), int'(e[WW-1:0])));
          if (chk_cyc) chk($sformatf("%s_s%0d_t%0d_cyc", nm, s, t), beats[n].cyc, acc + 2 + t);
        end
        n++;
      end
    end
    chk($sformatf("%s_s%0d_count", nm, s), beats.size(), n);
  endtask

  initial begin
    int a, a2, k, viol, nfound;
    int acc[2];
    int rsrc[4];
    rst_n = 1'b0; enable = 1'b1; in_valid = 1'b0; in_src_id = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;

    // Reset state
    nxt(); nxt(); nxt();
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_syn_valid", int'(syn_valid), 0);
    chk("rst_syn_weight", int'(syn_weight), 0);
    chk("rst_syn_exc", int'(syn_excitatory), 0);
    chk("rst_syn_target", int'(syn_target), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cfg_drop", int'(cfg_drop), 0);
    chk("rst_event_count", int'(event_count), 0);
    nxt(); rst_n = 1'b1;
    @(negedge clk); chk("ready_release_cycle", int'(in_ready), 0);
    nxt();
    @(negedge clk); chk("ready_after_release", int'(in_ready), 1);
    nxt();

    // Table-driven fan-out of src 5
    for (int t = 0; t < NN; t++) begin
      vt[t].wdata   = '{excitatory: (t % 2 == 0), magnitude: 8'(10 * t + 1)};
      vt[t].exp_tgt = t;
      vt[t].exp_w   = 10 * t + 1;
      vt[t].exp_exc = (t % 2 == 0) ? 1 : 0;
    end
    for (int t = 0; t < NN; t++) cfg_write(5, t, vt[t].wdata);
    beats.delete();
    send(5, a);
    wait_idle();
    chk("t1_count", beats.size(), NN);
    for (int i = 0; i < NN && i < beats.size(); i++) begin
      chk($sformatf("t1_beat%0d", i), pack(beats[i].tgt, beats[i].exc, beats[i].w),
          pack(vt[i].exp_tgt, vt[i].exp_exc, vt[i].exp_w));
      chk($sformatf("t1_cyc%0d", i), beats[i].cyc, a + 2 + i);
    end
    chk("t1_event_count", int'(event_count), 1);

    // Held in_valid: back-to-back accepts at minimum spacing
    do_reset();
    in_valid = 1'b1; in_src_id = 6'd3; k = 0; viol = 0;
    for (int i = 0; i < 80 && k < 2; i++) begin
      @(negedge clk);
      if (busy === 1'b1 && in_ready !== 1'b0) viol++;
      if (in_ready === 1'b1) begin acc[k] = cyc; k++; end
      nxt();
      if (k == 1) in_src_id = 6'd4;
    end
    in_valid = 1'b0;
    chk("t2_accepts", k, 2);
    chk("t2_spacing", acc[1] - acc[0], NN + 2);
    chk("t2_ready_low_busy", viol, 0);
    wait_idle();
    chk("t2_event_count", int'(event_count), 2);

    // Zero-weight slot on src 7, target 4
    for (int t = 0; t < NN; t++) cfg_write(7, t, (t == 4) ? 9'h100 : {1'b1, 8'(t + 1)});
    beats.delete();
    send(7, a);
    wait_idle();
    nfound = 0;
    foreach (beats[i]) if (beats[i].cyc == a + 6) nfound++;
`ifdef SYN_ZERO_SKIP_EN
    chk("t3_skip_slot_empty", nfound, 0);
`else
    chk("t3_slot_present", nfound, 1);
    if (beats.size() > 4) chk("t3_slot_weight", beats[4].w, 0);
`endif
    expect_row("t3", 7, a, 1);

    // Write while busy is dropped and flagged
    beats.delete();
    send(5, a);
    nxt(); nxt(); nxt();
    cfg_we = 1'b1; cfg_addr = {6'd5, 4'd3}; cfg_wdata = 9'h1AA;
    nxt();
    cfg_we = 1'b0;
    @(negedge clk); chk("t4_drop_pulse", int'(cfg_drop), 1);
    nxt();
    @(negedge clk); chk("t4_drop_clear", int'(cfg_drop), 0);
    nxt();
    wait_idle();
    beats.delete();
    send(5, a);
    wait_idle();
    if (beats.size() > 3) chk("t4_reread_w3", beats[3].w, 31);
    expect_row("t4", 5, a, 1);

    // enable low for 3 cycles after beat 5; busy writes meanwhile are ignored silently
    beats.delete();
    send(5, a);
    repeat (7) nxt();
    enable = 1'b0; cfg_we = 1'b1; cfg_addr = {6'd5, 4'd2}; cfg_wdata = 9'h000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t5_frozen_valid%0d", i), int'(syn_valid), 0);
      chk($sformatf("t5_frozen_drop%0d", i), int'(cfg_drop), 0);
      chk($sformatf("t5_frozen_ready%0d", i), int'(in_ready), 0);
      nxt();
    end
    enable = 1'b1; cfg_we = 1'b0;
    wait_idle();
    chk("t5_count", beats.size(), NN);
    if (beats.size() > 6) begin
      chk("t5_beat5_cyc", beats[5].cyc, a + 7);
      chk("t5_beat6_cyc", beats[6].cyc, a + 11);
    end
    expect_row("t5", 5, a, 0);

    // Reset during fan-out
    beats.delete();
    send(5, a);
    repeat (9) nxt();
    rst_n = 1'b0;
    @(negedge clk); chk("t6_beat8_seen", int'(syn_target), 8);
    nxt();
    @(negedge clk);
    chk("t6_valid", int'(syn_valid), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_target", int'(syn_target), 0);
    chk("t6_weight", int'(syn_weight), 0);
    chk("t6_exc", int'(syn_excitatory), 0);
    chk("t6_count", int'(event_count), 0);
    chk("t6_ready", int'(in_ready), 0);
    chk("t6_beats_before", beats.size(), 9);
    nxt(); rst_n = 1'b1; nxt(); nxt();
    beats.delete();
    send(5, a);
    wait_idle();
    expect_row("t6", 5, a, 1);

    // Write and accept in the same cycle: read-first returns the old word
    for (int t = 0; t < NN; t++) cfg_write(9, t, {1'b0, 8'(100 + t)});
    beats.delete();
    in_valid = 1'b1; in_src_id = 6'd9;
    cfg_we = 1'b1; cfg_addr = {6'd9, 4'd0}; cfg_wdata = 9'h107;
    @(negedge clk);
    chk("t7_ready", int'(in_ready), 1);
    a = cyc;
    nxt();
    in_valid = 1'b0; cfg_we = 1'b0;
    wait_idle();
    if (beats.size() > 0) chk("t7_old_word", pack(beats[0].tgt, beats[0].exc, beats[0].w), pack(0, 0, 100));
    mdl[9][0] = 9'h107;
    beats.delete();
    send(9, a2);
    wait_idle();
    expect_row("t7", 9, a2, 1);

    // Randomized events against the row model
    rsrc[0] = 20; rsrc[1] = 33; rsrc[2] = 47; rsrc[3] = 63;
    for (int r = 0; r < 4; r++)
      for (int t = 0; t < NN; t++)
        cfg_write(rsrc[r], t, {1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255))});
    for (int ev = 0; ev < 12; ev++) begin
      int s;
      if ($urandom_range(0, 2) == 0)
        cfg_write(rsrc[$urandom_range(0, 3)], $urandom_range(0, NN - 1),
                  {1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))});
      s = rsrc[$urandom_range(0, 3)];
      beats.delete();
      send(s, a);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 14)) nxt();
        enable = 1'b0;
        repeat ($urandom_range(1, 4)) nxt();
        enable = 1'b1;
      end
      wait_idle();
      expect_row("rnd", s, a, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
